// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap initiator.
package trap_pkg;

    // Width the cause constants below are defined against.
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        REDIRECT = 3'd2,
        HANDLER  = 3'd3,
        RETURN   = 3'd4
    } trap_state_e;

    localparam int unsigned CAUSE_ECALL_M        = 11;
    localparam int unsigned CAUSE_STACK_MISMATCH = 24;
    localparam int unsigned CAUSE_M_EXT_IRQ      = 11;
    localparam int unsigned CAUSE_IRQ_BIT        = XLEN_DEFAULT - 1;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio_enc.sv
// Priority encoder: stack_mismatch > ecall > gated external interrupt.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_stack_mismatch,
    input  logic            i_ecall,
    input  logic            i_irq,
    output logic            o_take,
    output logic [XLEN-1:0] o_cause
);

    localparam logic [XLEN-1:0] IRQ_FLAG = XLEN'(1) << (XLEN - 1);

    // Select the highest-priority pending source and its mcause encoding.
    always_comb begin
        o_take  = i_stack_mismatch | i_ecall | i_irq;
        o_cause = '0;
        if (i_stack_mismatch)
            o_cause = XLEN'(CAUSE_STACK_MISMATCH);
        else if (i_ecall)
            o_cause = XLEN'(CAUSE_ECALL_M);
        else if (i_irq)
            o_cause = IRQ_FLAG | XLEN'(CAUSE_M_EXT_IRQ);
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap initiator: accepts a trap at ID/EX, strobes the CSR
// file, flushes the pipeline, redirects fetch to mtvec and back to mepc
// on mret.
// Optional build macro TRAP_VECTORED_EN: vectored mtvec mode for interrupts.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic            ecall,
    input  logic            stack_mismatch,
    input  logic            uart_IRQ,
    input  logic            irq_en,
    input  logic            mret,
    input  logic [XLEN-1:0] ID_EX_pres_addr,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            trigger_trap,
    output logic [XLEN-1:0] trap_cause,
    output logic            flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_addr,
    output logic            trapping,
    output logic            double_fault
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    trap_state_e     r_state;
    logic [2:0]      r_cnt;
    logic [XLEN-1:0] r_cause;
    logic            r_dfault;

    logic            w_take;
    logic [XLEN-1:0] w_cause;
    logic            w_accept;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_addr;
    logic            w_unused_ok;

    trap_prio_enc #(
        .XLEN(XLEN)
    ) u_prio (
        .i_stack_mismatch(stack_mismatch),
        .i_ecall         (ecall),
        .i_irq           (uart_IRQ & irq_en),
        .o_take          (w_take),
        .o_cause         (w_cause)
    );

    // Accept only in IDLE; gated by Rst so outputs drop to 0 the moment reset asserts.
    assign w_accept = ~Rst & (r_state == IDLE) & ex_valid & ~stall & w_take;

    assign w_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // 4*cause[XLEN-2:0] modulo 2^XLEN is just the low cause bits shifted by two.
    always_comb begin
        w_vec_addr = w_base;
        if (mtvec[1:0] == MTVEC_MODE_VECTORED && r_cause[XLEN-1])
            w_vec_addr = w_base + {r_cause[XLEN-3:0], 2'b00};
    end
`else
    assign w_vec_addr = w_base;
`endif

    // Inputs carried for interface compatibility but not needed by this logic.
    assign w_unused_ok = ^{ID_EX_pres_addr, mtvec[1:0], r_cause};

    // Trap sequencing FSM, flush counter, cause latch and sticky double fault.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cause  <= '0;
            r_dfault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= FLUSH;
                        r_cnt   <= CNT_INIT;
                        r_cause <= w_cause;
                    end
                end
                FLUSH: begin
                    if (r_cnt == 3'd0)
                        r_state <= REDIRECT;
                    else
                        r_cnt <= r_cnt - 3'd1;
                end
                REDIRECT: r_state <= HANDLER;
                HANDLER: begin
                    if (ex_valid & (ecall | stack_mismatch))
                        r_dfault <= 1'b1;
                    if (mret & ex_valid & ~stall)
                        r_state <= RETURN;
                end
                RETURN:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output decode from state plus the same-cycle trap strobe.
    always_comb begin
        trigger_trap  = w_accept;
        trap_cause    = w_accept ? w_cause : '0;
        flush         = (r_state == FLUSH) | (r_state == REDIRECT) | (r_state == RETURN);
        pc_redirect   = (r_state == REDIRECT) | (r_state == RETURN);
        trapping      = (r_state == HANDLER) | (r_state == RETURN);
        double_fault  = r_dfault;
        redirect_addr = '0;
        if (r_state == REDIRECT)
            redirect_addr = w_vec_addr;
        else if (r_state == RETURN)
            redirect_addr = mepc;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (FLUSH_CYCLES=2, XLEN=32).
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        Rst;
    logic        ex_valid, stall, ecall, stack_mismatch, uart_IRQ, irq_en, mret;
    logic [31:0] ID_EX_pres_addr, mtvec, mepc;
    logic        trigger_trap, flush, pc_redirect, trapping, double_fault;
    logic [31:0] trap_cause, redirect_addr;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN        (32),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk            (clk),
        .Rst            (Rst),
        .ex_valid       (ex_valid),
        .stall          (stall),
        .ecall          (ecall),
        .stack_mismatch (stack_mismatch),
        .uart_IRQ       (uart_IRQ),
        .irq_en         (irq_en),
        .mret           (mret),
        .ID_EX_pres_addr(ID_EX_pres_addr),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .trigger_trap   (trigger_trap),
        .trap_cause     (trap_cause),
        .flush          (flush),
        .pc_redirect    (pc_redirect),
        .redirect_addr  (redirect_addr),
        .trapping       (trapping),
        .double_fault   (double_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ex_valid = 0; stall = 0; ecall = 0; stack_mismatch = 0;
        uart_IRQ = 0; mret = 0;
    endtask

    // Check the full control-output vector {trig,flush,redir,trapping}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, {28'd0, trigger_trap, flush, pc_redirect, trapping}, {28'd0, exp});
    endtask

    // Walk from HANDLER through mret/RETURN back to IDLE.
    task automatic do_return(input string tag, input logic [31:0] ret);
        mepc = ret; mret = 1; ex_valid = 1;
        chk_ctl({tag, "_hnd"}, 4'b0001);
        tick(); quiet();
        chk_ctl({tag, "_ret"}, 4'b0111);
        chk({tag, "_ret_addr"}, redirect_addr, ret);
        tick();
        chk_ctl({tag, "_idle"}, 4'b0000);
        chk({tag, "_idle_addr"}, redirect_addr, 32'h0);
    endtask

    initial begin
        Rst = 1; quiet(); irq_en = 0;
        ID_EX_pres_addr = 32'h100; mtvec = 32'h200; mepc = 32'h0;
        tick(); tick();
        ecall = 1; ex_valid = 1;
        chk_ctl("rst_ctl", 4'b0000);
        chk("rst_cause", trap_cause, 32'h0);
        chk("rst_df", {31'd0, double_fault}, 32'h0);
        quiet();
        Rst = 0;
        tick();

        // mret in IDLE does nothing
        mret = 1; ex_valid = 1;
        tick(); quiet();
        chk_ctl("idle_mret", 4'b0000);

        // Scenario 1: ecall, T..T+4
        ecall = 1; ex_valid = 1;
        chk_ctl("ec_T", 4'b1000);
        chk("ec_cause", trap_cause, 32'h0000000B);
        tick();
        chk_ctl("ec_T1_held", 4'b0100);   // ecall still high: no retrigger
        quiet();
        tick();
        chk_ctl("ec_T2", 4'b0100);
        tick();
        chk_ctl("ec_T3", 4'b0110);
        chk("ec_T3_addr", redirect_addr, 32'h200);
        tick();
        chk_ctl("ec_T4", 4'b0001);
        chk("ec_T4_addr", redirect_addr, 32'h0);
        uart_IRQ = 1; irq_en = 1; ex_valid = 1;
        chk_ctl("hnd_irq_masked", 4'b0001);
        tick(); quiet();
        do_return("ret1", 32'h104);

        // Scenario 2: all sources at once, stack_mismatch wins
        stack_mismatch = 1; ecall = 1; uart_IRQ = 1; irq_en = 1; ex_valid = 1;
        chk_ctl("prio_T", 4'b1000);
        chk("prio_cause", trap_cause, 32'h00000018);
        tick(); quiet();
        tick(); tick(); tick();
        do_return("ret2", 32'h300);

        // Scenario 3: interrupt gating and stall
        uart_IRQ = 1; irq_en = 0; ex_valid = 1;
        chk_ctl("irq_dis", 4'b0000);
        irq_en = 1; stall = 1;
        chk_ctl("irq_stall", 4'b0000);
        stall = 0; ex_valid = 0;
        chk_ctl("irq_novalid", 4'b0000);
        ex_valid = 1; mtvec = 32'h201;
        chk_ctl("irq_T", 4'b1000);
        chk("irq_cause", trap_cause, 32'h8000000B);
        tick(); quiet();
        tick(); tick();
        chk_ctl("irq_redir", 4'b0110);
`ifdef TRAP_VECTORED_EN
        chk("irq_vec_addr", redirect_addr, 32'h22C);
`else
        chk("irq_vec_addr", redirect_addr, 32'h200);
`endif
        tick();
        do_return("ret3", 32'h44);

        // Scenario 4: exception with vectored mtvec uses base; double fault
        ecall = 1; ex_valid = 1;
        chk_ctl("ec2_T", 4'b1000);
        tick(); quiet();
        tick(); tick();
        chk("ec2_addr", redirect_addr, 32'h200);
        tick();
        ecall = 1; ex_valid = 1;
        chk_ctl("df_no_trig", 4'b0001);
        tick(); quiet();
        chk("df_set", {31'd0, double_fault}, 32'h1);
        chk_ctl("df_still_hnd", 4'b0001);
        stack_mismatch = 1;      // mret honoured despite fault source
        do_return("ret_df", 32'h108);
        chk("df_sticky", {31'd0, double_fault}, 32'h1);

        // Async reset mid-FLUSH
        ecall = 1; ex_valid = 1;
        chk_ctl("rst2_T", 4'b1000);
        tick(); quiet();
        chk_ctl("rst2_flush", 4'b0100);
        #2 Rst = 1;
        #1;
        chk_ctl("rst2_ctl", 4'b0000);
        chk("rst2_df", {31'd0, double_fault}, 32'h0);
        chk("rst2_addr", redirect_addr, 32'h0);
        tick(); Rst = 0;
        tick();
        chk_ctl("rst2_idle", 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
